// File: rtl/shift_offset_sched_pkg.sv
// Shared types, sizing and modular-arithmetic helpers for the shift-offset
// sequencer of one share-group layer.
package shift_sched_pkg;

    localparam int SHARED_BANK_NUM = 5;
    localparam int SHIFT_WIDTH     = $clog2(SHARED_BANK_NUM);
    localparam int VN_MAX          = 8;
    localparam int VN_CNT_WIDTH    = $clog2(VN_MAX + 1);
    localparam int LAT             = 2;

    typedef logic [SHIFT_WIDTH-1:0]  shift_t;
    typedef logic [VN_CNT_WIDTH-1:0] vn_cnt_t;
    typedef logic [1:0]              state_t;

    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_ACCEPT = 2'd1;
    localparam state_t S_CALC   = 2'd2;
    localparam state_t S_EMIT   = 2'd3;

    typedef struct packed {
        logic    valid;
        logic    last;
        vn_cnt_t idx;
        shift_t  data;
    } pipe_stage_t;

    // Operands are below ws, so a single conditional subtract is a full modulo.
    function automatic shift_t mod_add(input shift_t a, input shift_t b, input shift_t ws);
        logic [SHIFT_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= {1'b0, ws}) begin
            sum = sum - {1'b0, ws};
        end
        return sum[SHIFT_WIDTH-1:0];
    endfunction

    function automatic shift_t preproc_shift(input shift_t o, input shift_t ws);
        return (o == '0) ? '0 : shift_t'(ws - o);
    endfunction

endpackage

// File: rtl/shift_offset_sched_mod_pipe.sv
// Registered mod-W^s adder: the sum is formed at the handshake and then carried
// through STAGES flops together with its VN index and last-VN flag.
module shift_mod_pipe
    import shift_sched_pkg::*;
#(
    parameter int STAGES = LAT
) (
    input  logic                    sys_clk,
    input  logic                    rstn,
    input  logic                    in_valid_i,
    input  logic                    in_last_i,
    input  logic [VN_CNT_WIDTH-1:0] in_idx_i,
    input  logic [SHIFT_WIDTH-1:0]  acc_i,
    input  logic [SHIFT_WIDTH-1:0]  shift_i,
    input  logic [SHIFT_WIDTH-1:0]  ws_i,
    output logic                    out_valid_o,
    output logic                    out_last_o,
    output logic [VN_CNT_WIDTH-1:0] out_idx_o,
    output logic [SHIFT_WIDTH-1:0]  out_data_o,
    output logic                    pre_valid_o
);
    pipe_stage_t stage_q [STAGES];
    pipe_stage_t stage_d [STAGES];

    always_comb begin
        stage_d[0].valid = in_valid_i;
        stage_d[0].last  = in_last_i;
        stage_d[0].idx   = in_idx_i;
        stage_d[0].data  = mod_add(acc_i, shift_i, ws_i);
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // NOTE: the whole pipe is cleared, not just the valid bits, so a reset
    // mid-layer can never leak a stale offset or last flag into a new layer.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            stage_q <= '{default: '0};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out_valid_o = stage_q[STAGES-1].valid;
    assign out_last_o  = stage_q[STAGES-1].last;
    assign out_idx_o   = stage_q[STAGES-1].idx;
    assign out_data_o  = stage_q[STAGES-1].data;

    // Result lands on the output next cycle; lets the FSM enter EMIT in step.
    if (STAGES >= 2) begin : g_pre
        assign pre_valid_o = stage_q[STAGES-2].valid;
    end else begin : g_no_pre
        assign pre_valid_o = 1'b0;
    end

endmodule

// File: rtl/shift_offset_sched.sv
// Shift-offset sequencer for one share-group layer: accepts one shift per VN,
// accumulates O_m = (O_{m-1} + s_m) mod W^s and emits offsets in VN order.
module shift_offset_sched
    import shift_sched_pkg::*;
(
    input  logic                    sys_clk,
    input  logic                    rstn,
    input  logic                    start_i,
    input  logic [VN_CNT_WIDTH-1:0] vn_num_i,
    input  logic [SHIFT_WIDTH-1:0]  ws_i,
    input  logic                    shift_valid_i,
    input  logic [SHIFT_WIDTH-1:0]  shift_i,
    output logic                    shift_ready_o,
    output logic                    offset_valid_o,
    output logic [SHIFT_WIDTH-1:0]  offset_o,
    output logic [VN_CNT_WIDTH-1:0] vn_idx_o,
    output logic                    is_vnLast_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);
    state_t  state_q, state_d;
    vn_cnt_t vn_num_q, vn_num_d;
    vn_cnt_t vn_cnt_q, vn_cnt_d;
    shift_t  ws_q, ws_d;
    shift_t  acc_q, acc_d;
    logic    done_q, done_d;

    logic    cfg_bad, start_ok, handshake, shift_bad, is_last_vn;
    shift_t  shift_eff, acc_eff;
    logic    pipe_valid, pipe_pre_valid, pipe_last;
    vn_cnt_t pipe_idx;
    shift_t  pipe_data;

    always_comb begin
        cfg_bad    = (vn_num_i == '0) || (vn_num_i > vn_cnt_t'(VN_MAX)) ||
                     (ws_i == '0) || (ws_i > shift_t'(SHARED_BANK_NUM));
        start_ok   = start_i && (state_q == S_IDLE) && !cfg_bad;
        handshake  = shift_valid_i && (state_q == S_ACCEPT);
        // An out-of-range shift is flagged but contributes nothing to the sum.
        shift_bad  = handshake && (shift_i >= ws_q);
        shift_eff  = shift_bad ? '0 : shift_i;
        acc_eff    = (vn_cnt_q == '0) ? '0 : acc_q;
        is_last_vn = (vn_cnt_q == vn_num_q - vn_cnt_t'(1));
    end

    shift_mod_pipe #(.STAGES(LAT)) u_pipe (
        .sys_clk    (sys_clk),
        .rstn       (rstn),
        .in_valid_i (handshake),
        .in_last_i  (is_last_vn),
        .in_idx_i   (vn_cnt_q),
        .acc_i      (acc_eff),
        .shift_i    (shift_eff),
        .ws_i       (ws_q),
        .out_valid_o(pipe_valid),
        .out_last_o (pipe_last),
        .out_idx_o  (pipe_idx),
        .out_data_o (pipe_data),
        .pre_valid_o(pipe_pre_valid)
    );

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start_ok)       state_d = S_ACCEPT;
            S_ACCEPT: if (handshake)      state_d = (LAT == 1) ? S_EMIT : S_CALC;
            S_CALC:   if (pipe_pre_valid) state_d = S_EMIT;
            S_EMIT:   state_d = pipe_last ? S_IDLE : S_ACCEPT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        vn_num_d = vn_num_q;
        ws_d     = ws_q;
        acc_d    = acc_q;
        vn_cnt_d = vn_cnt_q;
        done_d   = 1'b0;
        if (start_ok) begin
            vn_num_d = vn_num_i;
            ws_d     = ws_i;
            acc_d    = '0;
            vn_cnt_d = '0;
        end
        if (state_q == S_EMIT) begin
            acc_d  = pipe_data;
            done_d = pipe_valid && pipe_last;
            if (!pipe_last) begin
                vn_cnt_d = vn_cnt_q + vn_cnt_t'(1);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            vn_num_q <= '0;
            ws_q     <= '0;
            acc_q    <= '0;
            vn_cnt_q <= '0;
            done_q   <= 1'b0;
        end else begin
            vn_num_q <= vn_num_d;
            ws_q     <= ws_d;
            acc_q    <= acc_d;
            vn_cnt_q <= vn_cnt_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        shift_ready_o  = (state_q == S_ACCEPT);
        offset_valid_o = (state_q == S_EMIT);
        is_vnLast_o    = (state_q == S_EMIT) && pipe_last;
        offset_o       = '0;
        vn_idx_o       = '0;
        if (state_q == S_EMIT) begin
            offset_o = pipe_last ? preproc_shift(pipe_data, ws_q) : pipe_data;
            vn_idx_o = pipe_idx;
        end
        busy_o = (state_q != S_IDLE);
        done_o = done_q;
        err_o  = rstn && ((start_i && ((state_q != S_IDLE) || cfg_bad)) || shift_bad);
    end

endmodule

// File: doc/shift_offset_sched.md
Name: shift_offset_sched

Overview:
Controller that sequences the shift-offset accumulation for one layer of a share group (GP2).
- Accepts one base-matrix shift s_m per VN (f0..fN-1) through a valid/ready handshake.
- Computes the running offset O_m = (O_{m-1} + s_m) mod W^s in a LAT-stage pipeline. O_{-1} is forced to 0 at VN.f0.
- Enforces the read-after-write dependency on O_{m-1} by stalling intake until each result returns.
- For the last VN, emits the V2C preprocessing shift instead of O_m. Sits between the layer scheduler (shift source) and the L2PA/V2C permutation control.

Parameters:
SHARED_BANK_NUM, 5, max W^s (IB-LUTs in a share group)
SHIFT_WIDTH, $clog2(SHARED_BANK_NUM), shift/offset width
VN_MAX, 8, max VNs per layer
VN_CNT_WIDTH, $clog2(VN_MAX+1), VN count width
LAT, 2, cycles from shift handshake to offset_valid_o (>=1)

Ports:
sys_clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
start_i  in  1  layer start pulse; latches vn_num_i and ws_i
vn_num_i  in  VN_CNT_WIDTH  VNs in this layer (1..VN_MAX)
ws_i  in  SHIFT_WIDTH  W^s for this layer (1..SHARED_BANK_NUM)
shift_valid_i  in  1  shift_i valid
shift_i  in  SHIFT_WIDTH  s_m for current VN
shift_ready_o  out  1  block can accept shift_i
offset_valid_o  out  1  one-cycle pulse, offset_o valid
offset_o  out  SHIFT_WIDTH  O_m, or preprocessing shift for the last VN
vn_idx_o  out  VN_CNT_WIDTH  VN index of offset_o
is_vnLast_o  out  1  offset_o belongs to the last VN
busy_o  out  1  layer in progress
done_o  out  1  one-cycle pulse after the last offset
err_o  out  1  one-cycle protocol-error pulse

Behaviour:
- Reset: every output is 0; FSM is in IDLE; accumulator, VN counter and latched config are 0. Reset mid-layer abandons the layer with no done_o. The next start_i begins with O_{-1}=0.
- FSM states: IDLE, ACCEPT, CALC, EMIT.
- IDLE:
  - start_i with valid config: latch cfg, clear acc and VN counter, go to ACCEPT; busy_o=1 from the next cycle.
  - Invalid config (vn_num_i=0, vn_num_i>VN_MAX, ws_i=0, ws_i>SHARED_BANK_NUM): err_o pulses, stay in IDLE.
- ACCEPT:
  - shift_ready_o=1, driven from a register and never combinationally dependent on shift_valid_i.
  - On valid&ready, capture s_m and go to CALC.
- CALC: shift_ready_o=0. The sum advances through the LAT pipeline stages.
  - Arithmetic: sum = acc + s_m in SHIFT_WIDTH+1 bits.
  - If sum >= ws, the result is sum - ws; otherwise it is sum.
  - For VN index 0, acc is masked to 0.
- EMIT:
  - Timing: the handshake occurs at cycle t; offset_valid_o=1 in cycle t+LAT.
  - Normal VN: acc <= O_m; offset_o = O_m.
  - Last VN (index = vn_num-1): is_vnLast_o=1 and offset_o = (O_m==0) ? 0 : ws - O_m.
  - Not last: increment VN counter, go to ACCEPT; shift_ready_o returns at t+LAT+1.
  - Last: done_o pulses at t+LAT+1, busy_o drops at t+LAT+1, go to IDLE.
- Throughput: one VN per LAT+1 cycles.
- shift_i >= ws: err_o pulses in the handshake cycle and s_m is treated as 0. The layer continues.
- start_i while busy_o=1: ignored; err_o pulses.
- start_i in the same cycle as done_o: accepted (FSM is in IDLE that cycle).
- shift_valid_i outside ACCEPT: ignored, with no error. The source must hold shift_i until ready.
- ws_i and vn_num_i are sampled only at start_i; changes mid-layer have no effect.

Decomposition:
- Package shift_sched_pkg holds:
  - FSM state encoding (localparams S_IDLE, S_ACCEPT, S_CALC, S_EMIT).
  - Function mod_add(a, b, ws) implementing the width rule above.
  - Function preproc_shift(o, ws).
- One sub-module, shift_mod_pipe: the LAT-stage registered mod-add with valid/last/index sideband. The FSM lives in the top.

Test Plan:
- ws=5, vn_num=3, shifts 3,4,2 with valid held high → offsets 3, 2, then 1 (last, O=4 → 5-4=1). is_vnLast_o only on the third pulse; offset_valid_o pulses spaced 3 cycles apart; done_o one cycle after the third pulse.
- ws=5, vn_num=2, shifts 2,3 → offsets 2, then 0 (O=0 → preproc 0). Then start_i in the done_o cycle with ws=3, shifts 2,2 → 2, then 2 (O=1 → 3-1=2); acc starts from 0.
- Backpressure: shift_valid_i delayed 4 cycles after ready → offset_valid_o exactly LAT cycles after the actual handshake. Valid asserted during CALC is not consumed early.
- Errors:
  - shift_i=6 with ws=5 → err_o pulse, treated as 0.
  - start_i while busy → err_o, layer unaffected.
  - ws_i=0 or vn_num_i=0 → err_o, busy_o stays 0.
- vn_num=1, ws=5, shift 0 → single pulse with offset_o=0, is_vnLast_o=1, vn_idx_o=0; then done_o.
- rstn low for 1 cycle during CALC of VN1 → all outputs 0 next cycle, no done_o. A new layer (ws=5, shifts 4,4) → 4, then 2 (O=3 → 5-3=2).
